// File: rtl/dm_responder.sv
// Data-memory responder: word RAM with byte-lane writes, an MMIO window (LED, timer, switches)
// and a registered debug read port. All reads return one cycle after the address.
module dm_responder #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [15:0] MMIO_HI    = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [31:0]           dm_addr,
    input  logic [3:0]            dm_wen,
    input  logic [31:0]           dm_wdata,
    output logic [31:0]           dm_rdata,
    input  logic [15:0]           switch_in,
    output logic [15:0]           led_out,
    input  logic [ADDR_WIDTH-1:0] test_addr,
    output logic [31:0]           test_data
);
    localparam logic [15:0] OFF_LED    = 16'h0000;
    localparam logic [15:0] OFF_TIMER  = 16'h0004;
    localparam logic [15:0] OFF_SWITCH = 16'h0008;

    typedef struct packed {
        logic                  mmio;
        logic [ADDR_WIDTH-1:0] idx;
        logic [15:0]           off;
    } dm_req_t;

    logic [3:0][7:0] mem [1<<ADDR_WIDTH];
    dm_req_t         req;
    logic [15:0]     led_q;
    logic [31:0]     timer_q;
    logic [31:0]     mmio_rdata;
    logic            wr_led;
    logic            wr_timer;

    assign req.mmio = (dm_addr[31:16] == MMIO_HI);
    assign req.idx  = dm_addr[ADDR_WIDTH+1:2];
    assign req.off  = dm_addr[15:0];
    assign wr_led   = req.mmio && (req.off == OFF_LED);
    assign wr_timer = req.mmio && (req.off == OFF_TIMER) && (|dm_wen);
    assign led_out  = led_q;

    always_comb begin
        mmio_rdata = '0;
        case (req.off)
            OFF_LED:    mmio_rdata = {16'd0, led_q};
            OFF_TIMER:  mmio_rdata = timer_q;
            OFF_SWITCH: mmio_rdata = {16'd0, switch_in};
            default:    mmio_rdata = '0;
        endcase
    end

    // RAM has no reset; gating with resetn drops any write presented while reset is held.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (resetn && !req.mmio && dm_wen[i])
                mem[req.idx][i] <= dm_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dm_rdata  <= '0;
            test_data <= '0;
        end else begin
            dm_rdata  <= req.mmio ? mmio_rdata : mem[req.idx];
            test_data <= mem[test_addr];
        end
    end

    // A timer write replaces the increment for that cycle; unwritten lanes hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q   <= '0;
            timer_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_led && dm_wen[i])
                    led_q[8*i +: 8] <= dm_wdata[8*i +: 8];
            end
            if (wr_timer) begin
                for (int i = 0; i < 4; i++) begin
                    if (dm_wen[i])
                        timer_q[8*i +: 8] <= dm_wdata[8*i +: 8];
                end
            end else begin
                timer_q <= timer_q + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: expected read data queued at drive time, popped after the edge.
module tb_dm_responder;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   dm_addr = '0;
    logic [3:0]    dm_wen = '0;
    logic [31:0]   dm_wdata = '0;
    logic [31:0]   dm_rdata;
    logic [15:0]   switch_in = '0;
    logic [15:0]   led_out;
    logic [AW-1:0] test_addr = '0;
    logic [31:0]   test_data;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    dm_responder #(.ADDR_WIDTH(AW), .MMIO_HI(16'hFFFF)) dut (
        .clk(clk), .resetn(resetn), .dm_addr(dm_addr), .dm_wen(dm_wen),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .switch_in(switch_in),
        .led_out(led_out), .test_addr(test_addr), .test_data(test_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle, entered and left at a negedge. With chk_en, dm_rdata after this
    // cycle's edge must equal e.
    task automatic cyc(input string tag, input logic [31:0] a, input logic [3:0] w,
                       input logic [31:0] d, input bit chk_en, input logic [31:0] e);
        dm_addr = a; dm_wen = w; dm_wdata = d;
        if (chk_en) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        @(posedge clk); #1;
        if (chk_en) chk(tag_q.pop_front(), dm_rdata, exp_q.pop_front());
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_rdata", dm_rdata, 32'h0);
        chk("rst_test", test_data, 32'h0);
        chk("rst_led", {16'd0, led_out}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Seed RAM words used later
        cyc("init20", 32'h20, 4'b1111, 32'h0, 0, 0);
        cyc("init0", 32'h0, 4'b1111, 32'h0BADF00D, 0, 0);

        // Word store/load and debug port
        test_addr = 8'd4;
        cyc("st10", 32'h10, 4'b1111, 32'hDEADBEEF, 0, 0);
        cyc("ld10", 32'h10, 4'b0000, 32'h0, 1, 32'hDEADBEEF);
        chk("dbg4", test_data, 32'hDEADBEEF);

        // Byte lanes (address low bits ignored)
        cyc("st12_b2", 32'h12, 4'b0100, 32'h00AA0000, 0, 0);
        cyc("ld_b2", 32'h10, 4'b0000, 32'h0, 1, 32'hDEAABEEF);
        cyc("st_b3_rf", 32'h10, 4'b1000, 32'h11000000, 1, 32'hDEAABEEF);
        cyc("ld_b3", 32'h10, 4'b0000, 32'h0, 1, 32'h11AABEEF);

        // Read-during-write returns old word
        cyc("rdw_old", 32'h20, 4'b1111, 32'h12345678, 1, 32'h0);
        cyc("rdw_new", 32'h20, 4'b0000, 32'h0, 1, 32'h12345678);

        // MMIO
        cyc("led_wr", 32'hFFFF0000, 4'b1111, 32'hFFFFA5A5, 1, 32'h0);
        chk("led_out", {16'd0, led_out}, 32'h0000A5A5);
        cyc("led_rd", 32'hFFFF0000, 4'b0000, 32'h0, 1, 32'h0000A5A5);
        switch_in = 16'h0F0F;
        cyc("sw_rd", 32'hFFFF0008, 4'b0000, 32'h0, 1, 32'h00000F0F);
        cyc("unmap_wr", 32'hFFFF000C, 4'b1111, 32'hFFFFFFFF, 1, 32'h0);
        cyc("unmap_rd", 32'hFFFF000C, 4'b0000, 32'h0, 1, 32'h0);
        cyc("ram0_keep", 32'h0, 4'b0000, 32'h0, 1, 32'h0BADF00D);
        cyc("ram_alias", 32'h400, 4'b0000, 32'h0, 1, 32'h0BADF00D);

        // Timer wrap
        cyc("tmr_wr", 32'hFFFF0004, 4'b1111, 32'hFFFFFFFE, 0, 0);
        cyc("tmr_fe", 32'hFFFF0004, 4'b0000, 32'h0, 1, 32'hFFFFFFFE);
        cyc("tmr_ff", 32'hFFFF0004, 4'b0000, 32'h0, 1, 32'hFFFFFFFF);
        cyc("tmr_wrap", 32'hFFFF0004, 4'b0000, 32'h0, 1, 32'h00000000);

        // Timer partial write suppresses the increment
        cyc("tmr_wr2", 32'hFFFF0004, 4'b1111, 32'h000001FE, 0, 0);
        cyc("tmr_1fe", 32'hFFFF0004, 4'b0000, 32'h0, 1, 32'h000001FE);
        cyc("tmr_b0wr", 32'hFFFF0004, 4'b0001, 32'h0, 1, 32'h000001FF);
        cyc("tmr_100", 32'hFFFF0004, 4'b0000, 32'h0, 1, 32'h00000100);
        cyc("tmr_101", 32'hFFFF0004, 4'b0000, 32'h0, 1, 32'h00000101);

        // Async reset mid-load; write during reset must be dropped
        dm_addr = 32'h10; dm_wen = 4'b0000;
        @(posedge clk); #1;
        chk("pre_rst_ld", dm_rdata, 32'h11AABEEF);
        #1;
        dm_wen = 4'b1111; dm_wdata = 32'hFFFFFFFF;
        resetn = 1'b0;
        #1;
        chk("arst_rdata", dm_rdata, 32'h0);
        chk("arst_led", {16'd0, led_out}, 32'h0);
        @(posedge clk); #1;
        chk("rst_hold", dm_rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        cyc("ram_kept", 32'h10, 4'b0000, 32'h0, 1, 32'h11AABEEF);
        cyc("tmr_after", 32'hFFFF0004, 4'b0000, 32'h0, 1, 32'h00000001);

        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
